uart_tx_feeder: RTL and testbench

Byte buffer and handshake sequencer directly upstream of the RS-232 transmitter. It accepts bytes from user logic into a FIFO and presents them one at a time on TxData. For each byte it generates a clean TxEn rising edge, holds TxData stable for the whole frame, and waits for the transmitter's TxDone before launching the next byte. User logic can queue bursts without tracking transmitter timing.

---
 rtl/uart_tx_feeder.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus TxEn/TxDone handshake sequencer in front of an RS-232 transmitter.
// One byte per frame; a new frame starts only after a fresh TxDone rising edge and a guard gap.
module uart_tx_feeder #(
    parameter int AW      = 4,
    parameter int EN_HOLD = 4,
    parameter int GAP_CYC = 64
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WrEn,
    input  logic [7:0]    WrData,
    input  logic          Flush,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Count,
    output logic          Overflow,
    output logic          Busy,
    output logic          TxEn,
    output logic [7:0]    TxData,
    input  logic          TxDone
);

    localparam int DEPTH   = 1 << AW;
    localparam int CNT_MAX = (EN_HOLD > GAP_CYC) ? EN_HOLD : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] EN_LAST  = CW'(EN_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            reject;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            done_d1;
    logic            done_d2;
    logic            done_d3;
    logic            done_rise;

    assign Full   = (count == FULL_CNT);
    assign Empty  = (count == '0);
    assign Count  = count;
    assign Busy   = (state != S_IDLE);

    // Flush wins over both the write and the head pop issued from IDLE
    assign push   = WrEn & ~Full & ~Flush;
    assign reject = WrEn &  Full & ~Flush;
    assign pop    = (state == S_IDLE) & ~Empty & ~Flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Overflow <= 1'b0;
        end else begin
            Overflow <= reject;
        end
    end

    // Head byte is captured on the edge that enters LOAD and held until the next LOAD
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            TxData <= 8'h00;
        end else if (pop) begin
            TxData <= mem[rd_ptr];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            done_d1 <= 1'b0;
            done_d2 <= 1'b0;
            done_d3 <= 1'b0;
        end else begin
            done_d1 <= TxDone;
            done_d2 <= done_d1;
            done_d3 <= done_d2;
        end
    end

    // Edge-only so a TxDone level left high from the previous frame cannot complete this one
    assign done_rise = done_d2 & ~done_d3;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            TxEn  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            TxEn  <= (state_nxt == S_STROBE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == EN_LAST) begin
                    state_nxt = S_WAIT_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected bytes, a monitor checks each TxEn frame.
module tb_uart_tx_feeder;

    localparam int AW      = 4;
    localparam int EN_HOLD = 4;
    localparam int GAP_CYC = 64;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          WrEn = 1'b0;
    logic [7:0]    WrData = 8'h00;
    logic          Flush = 1'b0;
    logic          TxDone = 1'b0;
    logic          Full;
    logic          Empty;
    logic [AW:0]   Count;
    logic          Overflow;
    logic          Busy;
    logic          TxEn;
    logic [7:0]    TxData;

    int            total = 0;
    int            bad = 0;
    logic [7:0]    sb [$];

    always #5 Clk = ~Clk;

    uart_tx_feeder #(
        .AW      (AW),
        .EN_HOLD (EN_HOLD),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .WrEn     (WrEn),
        .WrData   (WrData),
        .Flush    (Flush),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count),
        .Overflow (Overflow),
        .Busy     (Busy),
        .TxEn     (TxEn),
        .TxData   (TxData),
        .TxDone   (TxDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        WrEn   = 1'b1;
        WrData = b;
        @(negedge Clk);
        WrEn   = 1'b0;
    endtask

    task automatic wait_txen(input logic lvl, input string name);
        int n = 0;
        while (TxEn !== lvl && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check(name, 32'(TxEn === lvl), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy !== 1'b0 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check(name, 32'(Busy === 1'b0), 32'd1);
    endtask

    task automatic pulse_done();
        TxDone = 1'b1;
        repeat (2) @(negedge Clk);
        TxDone = 1'b0;
    endtask

    // Monitor: every TxEn rise must match the next queued byte and last exactly EN_HOLD clocks
    initial begin : monitor
        logic       prev;
        int         len;
        logic [7:0] e;
        prev = 1'b0;
        len  = 0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                prev = 1'b0;
                len  = 0;
            end else begin
                if (TxEn && !prev) begin
                    check("txen_rise_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("txdata_frame", 32'(TxData), 32'(e));
                    end
                end
                if (TxEn) begin
                    len++;
                end else if (prev) begin
                    check("txen_width", 32'(len), 32'(EN_HOLD));
                    len = 0;
                end
                prev = TxEn;
            end
        end
    end

    initial begin : stim
        logic [7:0] b;
        int         highs;

        // Reset state
        @(negedge Clk);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_txen", 32'(TxEn), 32'd0);
        check("rst_txdata", 32'(TxData), 32'h00);
        check("rst_overflow", 32'(Overflow), 32'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single byte with exact latency
        sb.push_back(8'hA5);
        wr(8'hA5);
        check("single_count_after_wr", 32'(Count), 32'd1);
        check("single_empty_after_wr", 32'(Empty), 32'd0);
        check("single_busy_before_load", 32'(Busy), 32'd0);
        @(negedge Clk);
        check("single_txdata_load", 32'(TxData), 32'hA5);
        check("single_busy_load", 32'(Busy), 32'd1);
        check("single_txen_load", 32'(TxEn), 32'd0);
        check("single_count_load", 32'(Count), 32'd0);
        for (int i = 0; i < EN_HOLD; i++) begin
            @(negedge Clk);
            check("single_txen_high", 32'(TxEn), 32'd1);
        end
        @(negedge Clk);
        check("single_txen_low", 32'(TxEn), 32'd0);
        check("single_busy_wait", 32'(Busy), 32'd1);
        pulse_done();
        repeat (GAP_CYC) @(negedge Clk);
        check("single_busy_gap_end", 32'(Busy), 32'd1);
        @(negedge Clk);
        check("single_busy_idle", 32'(Busy), 32'd0);

        // Burst of 17: first byte goes in flight, remaining 16 fill the FIFO
        for (int i = 0; i < 17; i++) begin
            b = 8'(i + 1);
            sb.push_back(b);
            wr(b);
        end
        check("burst_full", 32'(Full), 32'd1);
        check("burst_count16", 32'(Count), 32'd16);

        // Overflow while full and busy
        wr(8'hFF);
        check("ovf_pulse", 32'(Overflow), 32'd1);
        check("ovf_count", 32'(Count), 32'd16);
        @(negedge Clk);
        check("ovf_pulse_end", 32'(Overflow), 32'd0);
        check("ovf_count_hold", 32'(Count), 32'd16);

        wait_txen(1'b0, "burst_first_fall");
        pulse_done();
        for (int i = 1; i < 17; i++) begin
            wait_txen(1'b1, "burst_txen_rise");
            check("burst_count_dec", 32'(Count), 32'(16 - i));
            wait_txen(1'b0, "burst_txen_fall");
            pulse_done();
        end
        wait_idle("burst_idle");
        check("burst_empty_end", 32'(Empty), 32'd1);
        check("burst_sb_drained", 32'(sb.size()), 32'd0);

        // Stale TxDone held high through the gap must not finish the next frame
        sb.push_back(8'h21);
        wr(8'h21);
        sb.push_back(8'h22);
        wr(8'h22);
        wait_txen(1'b1, "stale_f1_rise");
        wait_txen(1'b0, "stale_f1_fall");
        TxDone = 1'b1;
        wait_txen(1'b1, "stale_f2_rise");
        wait_txen(1'b0, "stale_f2_fall");
        repeat (GAP_CYC + 10) @(negedge Clk);
        check("stale_no_advance_busy", 32'(Busy), 32'd1);
        check("stale_no_advance_txdata", 32'(TxData), 32'h22);
        TxDone = 1'b0;
        repeat (3) @(negedge Clk);
        pulse_done();
        wait_idle("stale_idle");

        // Flush during WAIT_DONE
        sb.push_back(8'h31);
        for (int i = 0; i < 5; i++) begin
            wr(8'(8'h31 + i));
        end
        wait_txen(1'b0, "flush_wait_done");
        check("flush_count_before", 32'(Count), 32'd4);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_count", 32'(Count), 32'd0);
        check("flush_empty", 32'(Empty), 32'd1);
        check("flush_txdata_kept", 32'(TxData), 32'h31);
        check("flush_busy", 32'(Busy), 32'd1);
        pulse_done();
        wait_idle("flush_idle");
        highs = 0;
        repeat (100) begin
            @(negedge Clk);
            if (TxEn) highs++;
        end
        check("flush_no_more_txen", 32'(highs), 32'd0);
        check("flush_txdata_final", 32'(TxData), 32'h31);

        // Flush beats a same-cycle write
        Flush  = 1'b1;
        WrEn   = 1'b1;
        WrData = 8'h77;
        @(negedge Clk);
        Flush  = 1'b0;
        WrEn   = 1'b0;
        check("flushwr_count", 32'(Count), 32'd0);
        check("flushwr_overflow", 32'(Overflow), 32'd0);
        @(negedge Clk);
        check("flushwr_no_load", 32'(Busy), 32'd0);

        // Asynchronous reset in the middle of STROBE
        sb.push_back(8'h41);
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        wait_txen(1'b1, "rst_mid_rise");
        @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check("rstmid_txen", 32'(TxEn), 32'd0);
        check("rstmid_count", 32'(Count), 32'd0);
        check("rstmid_txdata", 32'(TxData), 32'h00);
        check("rstmid_busy", 32'(Busy), 32'd0);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        highs = 0;
        repeat (200) begin
            @(negedge Clk);
            if (TxEn) highs++;
        end
        check("rstmid_quiet", 32'(highs), 32'd0);
        check("rstmid_empty", 32'(Empty), 32'd1);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
